// File: rtl/int_res_vec_reader.sv
// -----------------------------------------------------------------------------
// int_res_vec_reader
//
// Streaming read sequencer that sits directly upstream of the
// intermediate-results memory read port. A start command launches a strided
// sequence of single- or double-width reads. The 1-cycle-latency return data
// is captured into a 2-entry skid FIFO and presented on a valid/ready stream.
// The memory cannot stall, so reads are only issued while the FIFO has room
// for every read that is already on its way back.
//
// Optional feature: define INT_RES_RD_STALL_CNT_EN to build the backpressure
// counter behind stall_cycles; without it stall_cycles is tied to zero.
//
// Ports
//   clk                clock, rising edge
//   rst_n              asynchronous reset, active HIGH (name kept for the bus)
//   start              command strobe, accepted only while idle
//   start_addr         first element address
//   len                number of elements (0 = immediate done, no reads)
//   stride             address increment per element (wraps mod 2^ADDR_W)
//   cmd_data_width     0 = single width, 1 = double width
//   cmd_format         int-res format code
//   busy               high from accepted start until done
//   done               one-cycle pulse after the last element is accepted
//   mem_rd_en          memory read enable
//   mem_rd_addr        memory read address
//   mem_rd_data_width  latched read width (held for the whole command)
//   mem_rd_format      latched read format (held for the whole command)
//   mem_rd_data        read data, valid the cycle after mem_rd_en
//   out_valid          stream valid
//   out_ready          stream ready
//   out_data           stream data (FIFO head)
//   out_last           marks the final element
//   stall_cycles       backpressure cycle counter (saturating)
// -----------------------------------------------------------------------------
module int_res_vec_reader #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 22,
  parameter int FMT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] stride,
  input  logic              cmd_data_width,
  input  logic [FMT_W-1:0]  cmd_format,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_data_width,
  output logic [FMT_W-1:0]  mem_rd_format,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;

  logic [ADDR_W-1:0]   cur_addr_r;
  logic [ADDR_W-1:0]   stride_r;
  logic [LEN_W-1:0]    remain_r;
  logic                width_r;
  logic [FMT_W-1:0]    fmt_r;

  logic                inflight_r;
  logic                inflight_last_r;

  logic [DATA_W-1:0]   data0_r;
  logic [DATA_W-1:0]   data1_r;
  logic                last0_r;
  logic                last1_r;
  logic [1:0]          count_r;
  logic                valid_r;
  logic                out_last_r;

  logic [DATA_W-1:0]   data0_s;
  logic [DATA_W-1:0]   data1_s;
  logic                last0_s;
  logic                last1_s;
  logic [1:0]          count_s;

  logic                busy_r;
  logic                done_r;
  logic                done_s;

  logic                accept_s;
  logic                pop_s;
  logic                push_s;
  logic [2:0]          occ_s;
  logic                credit_ok_s;
  logic                issue_s;
  logic                last_issue_s;

  // Handshake and credit terms shared by the FSM and datapath.
  // A pop in the current cycle frees a slot before the new read can return,
  // which is what lets a continuous stream run at one element per cycle.
  // mem_rd_en is therefore combinational on out_ready.
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && start;
    pop_s        = valid_r && out_ready;
    push_s       = inflight_r;
    occ_s        = 3'({1'b0, count_r}) + 3'({2'b00, inflight_r}) - 3'({2'b00, pop_s});
    credit_ok_s  = (occ_s < 3'd2);
    issue_s      = (state_r == ST_ISSUE) && credit_ok_s;
    last_issue_s = issue_s && (remain_r == LEN_W'(1));
  end

  // Next-state and done-pulse decode.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len != LEN_W'(0)) begin
            state_s = ST_ISSUE;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (last_issue_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (pop_s && last0_r) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Skid FIFO next-state: slot 0 is always the head.
  always_comb begin
    data0_s = data0_r;
    data1_s = data1_r;
    last0_s = last0_r;
    last1_s = last1_r;
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_r == 2'd0) begin
          data0_s = mem_rd_data;
          last0_s = inflight_last_r;
        end else begin
          data1_s = mem_rd_data;
          last1_s = inflight_last_r;
        end
        count_s = count_r + 2'd1;
      end
      2'b01: begin
        data0_s = data1_r;
        last0_s = last1_r;
        count_s = count_r - 2'd1;
      end
      2'b11: begin
        if (count_r == 2'd1) begin
          data0_s = mem_rd_data;
          last0_s = inflight_last_r;
        end else begin
          data0_s = data1_r;
          last0_s = last1_r;
          data1_s = mem_rd_data;
          last1_s = inflight_last_r;
        end
      end
      default: begin
        count_s = count_r;
      end
    endcase
  end

  // FSM state, status pulses and the read-in-flight tracker.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r         <= ST_IDLE;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      state_r         <= state_s;
      busy_r          <= (state_s != ST_IDLE);
      done_r          <= done_s;
      inflight_r      <= issue_s;
      inflight_last_r <= last_issue_s;
    end
  end

  // Command latch and address/count walk.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cur_addr_r <= '0;
      stride_r   <= '0;
      remain_r   <= '0;
      width_r    <= 1'b0;
      fmt_r      <= '0;
    end else if (accept_s) begin
      cur_addr_r <= start_addr;
      stride_r   <= stride;
      remain_r   <= len;
      width_r    <= cmd_data_width;
      fmt_r      <= cmd_format;
    end else if (issue_s) begin
      cur_addr_r <= cur_addr_r + stride_r;
      remain_r   <= remain_r - LEN_W'(1);
    end else begin
      cur_addr_r <= cur_addr_r;
      remain_r   <= remain_r;
    end
  end

  // FIFO storage and registered stream outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data0_r    <= '0;
      data1_r    <= '0;
      last0_r    <= 1'b0;
      last1_r    <= 1'b0;
      count_r    <= 2'd0;
      valid_r    <= 1'b0;
      out_last_r <= 1'b0;
    end else begin
      data0_r    <= data0_s;
      data1_r    <= data1_s;
      last0_r    <= last0_s;
      last1_r    <= last1_s;
      count_r    <= count_s;
      valid_r    <= (count_s != 2'd0);
      out_last_r <= last0_s && (count_s != 2'd0);
    end
  end

`ifdef INT_RES_RD_STALL_CNT_EN
  logic [15:0] stall_r;

  // Saturating count of cycles where valid data waits on a stalled consumer.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      stall_r <= 16'd0;
    end else if (accept_s) begin
      stall_r <= 16'd0;
    end else if (busy_r && valid_r && !out_ready && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cycles = stall_r;
`else
  assign stall_cycles = 16'd0;
`endif

  assign busy              = busy_r;
  assign done              = done_r;
  assign mem_rd_en         = issue_s;
  assign mem_rd_addr       = cur_addr_r;
  assign mem_rd_data_width = width_r;
  assign mem_rd_format     = fmt_r;
  assign out_valid         = valid_r;
  assign out_data          = data0_r;
  assign out_last          = out_last_r;

endmodule
